// File: rtl/bwt_pkg.sv
// Shared types and default sizes for the streaming BWT core.
package bwt_pkg;

    localparam int SYM_W_DEF   = 8;
    localparam int MAX_LEN_DEF = 128;

    // Drain-side sequencing: wait for a full bank, request a sort,
    // stream the SA indices, then wait for the last output beat.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } drain_st_e;

endpackage

// File: rtl/bwt_bank_buf.sv
// Ping-pong block storage: two banks of MAX_LEN symbols with per-bank
// length and full flags, one write port, one random read port and a
// flat view of the selected bank for the external sorter.
module bwt_bank_buf
    import bwt_pkg::*;
#(
    parameter int SYM_W   = SYM_W_DEF,
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int IDX_W   = $clog2(MAX_LEN),
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     wr_en_i,
    input  logic                     wr_bank_i,
    input  logic [IDX_W-1:0]         wr_addr_i,
    input  logic [SYM_W-1:0]         wr_data_i,
    input  logic                     close_i,
    input  logic [LEN_W-1:0]         close_len_i,
    input  logic                     release_i,
    input  logic                     rel_bank_i,
    input  logic                     rd_bank_i,
    input  logic [IDX_W-1:0]         rd_addr_i,
    output logic [SYM_W-1:0]         rd_data_o,
    output logic [MAX_LEN*SYM_W-1:0] flat_o,
    output logic [LEN_W-1:0]         rd_len_o,
    output logic [1:0]               full_o
);

    logic [SYM_W-1:0] mem_q [2][MAX_LEN];
    logic [LEN_W-1:0] len_q [2];
    logic [1:0]       full_q;

    // Symbol storage; contents need no reset since full flags gate use.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_bank_i][wr_addr_i] <= wr_data_i;
        end
    end

    // Per-bank bookkeeping; close and release always target different banks.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full_q   <= 2'b00;
            len_q[0] <= {LEN_W{1'b0}};
            len_q[1] <= {LEN_W{1'b0}};
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (close_i && (wr_bank_i == b[0])) begin
                    full_q[b] <= 1'b1;
                    len_q[b]  <= close_len_i;
                end else if (release_i && (rel_bank_i == b[0])) begin
                    full_q[b] <= 1'b0;
                end
            end
        end
    end

    for (genvar i = 0; i < MAX_LEN; i++) begin : g_flat
        assign flat_o[i*SYM_W +: SYM_W] = mem_q[rd_bank_i][i];
    end

    assign rd_data_o = mem_q[rd_bank_i][rd_addr_i];
    assign rd_len_o  = len_q[rd_bank_i];
    assign full_o    = full_q;

endmodule

// File: rtl/bwt_stream_core.sv
// Streaming BWT: loads variable-length blocks into ping-pong banks,
// requests an external suffix sort per block and turns the returned
// SA index stream into BWT symbols plus the primary index.
module bwt_stream_core
    import bwt_pkg::*;
#(
    parameter int SYM_W   = SYM_W_DEF,
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int IDX_W   = $clog2(MAX_LEN),
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SYM_W-1:0]         in_data,
    input  logic                     in_last,
    output logic                     sort_start,
    output logic [LEN_W-1:0]         sort_len,
    output logic [MAX_LEN*SYM_W-1:0] sort_str,
    input  logic                     sa_valid,
    output logic                     sa_ready,
    input  logic [IDX_W-1:0]         sa_idx,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SYM_W-1:0]         out_data,
    output logic                     out_last,
    output logic [IDX_W-1:0]         out_primary,
    output logic                     err
);

    logic             wr_bank_q, wr_bank_d;
    logic [IDX_W-1:0] wr_cnt_q, wr_cnt_d;
    logic             in_ready_q, in_ready_d;

    drain_st_e        state_q;
    logic             rd_bank_q;
    logic [IDX_W-1:0] k_q, prim_q;
    logic             sort_start_q;
    logic [LEN_W-1:0] sort_len_q;
    logic             out_valid_q, out_last_q, err_q;
    logic [SYM_W-1:0] out_data_q;
    logic [IDX_W-1:0] out_primary_q;

    logic             acc_s, close_s, release_s;
    logic [LEN_W-1:0] close_len_s, rd_len_s;
    logic [1:0]       full_s, full_nxt_s;
    logic             sa_ready_s, sa_hs_s, idx_bad_s, beat_last_s;
    logic [IDX_W-1:0] last_idx_s, rd_addr_s;
    logic [SYM_W-1:0] rd_data_s;

    assign acc_s       = in_valid && in_ready_q;
    assign close_s     = acc_s && (in_last || (wr_cnt_q == IDX_W'(MAX_LEN - 1)));
    assign close_len_s = LEN_W'(wr_cnt_q) + LEN_W'(1'b1);
    assign release_s   = (state_q == ST_DONE) && out_valid_q && out_ready && out_last_q;

    bwt_bank_buf #(
        .SYM_W  (SYM_W),
        .MAX_LEN(MAX_LEN),
        .IDX_W  (IDX_W),
        .LEN_W  (LEN_W)
    ) u_buf (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .wr_en_i    (acc_s),
        .wr_bank_i  (wr_bank_q),
        .wr_addr_i  (wr_cnt_q),
        .wr_data_i  (in_data),
        .close_i    (close_s),
        .close_len_i(close_len_s),
        .release_i  (release_s),
        .rel_bank_i (rd_bank_q),
        .rd_bank_i  (rd_bank_q),
        .rd_addr_i  (rd_addr_s),
        .rd_data_o  (rd_data_s),
        .flat_o     (sort_str),
        .rd_len_o   (rd_len_s),
        .full_o     (full_s)
    );

    // Load-side next state; in_ready is registered from next-cycle bank occupancy.
    always_comb begin
        full_nxt_s = full_s;
        if (release_s) begin
            full_nxt_s[rd_bank_q] = 1'b0;
        end else begin
            full_nxt_s[rd_bank_q] = full_s[rd_bank_q];
        end
        if (close_s) begin
            full_nxt_s[wr_bank_q] = 1'b1;
            wr_bank_d             = ~wr_bank_q;
            wr_cnt_d              = {IDX_W{1'b0}};
        end else if (acc_s) begin
            wr_bank_d = wr_bank_q;
            wr_cnt_d  = wr_cnt_q + IDX_W'(1'b1);
        end else begin
            wr_bank_d = wr_bank_q;
            wr_cnt_d  = wr_cnt_q;
        end
        in_ready_d = !full_nxt_s[wr_bank_d];
    end

    // Load-side registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank_q  <= 1'b0;
            wr_cnt_q   <= {IDX_W{1'b0}};
            in_ready_q <= 1'b0;
        end else begin
            wr_bank_q  <= wr_bank_d;
            wr_cnt_q   <= wr_cnt_d;
            in_ready_q <= in_ready_d;
        end
    end

    // SA index to source address; out-of-range indices read as index 0.
    always_comb begin
        sa_ready_s  = (state_q == ST_STREAM) && (!out_valid_q || out_ready);
        sa_hs_s     = sa_valid && sa_ready_s;
        idx_bad_s   = (LEN_W'(sa_idx) >= sort_len_q);
        last_idx_s  = IDX_W'(sort_len_q - LEN_W'(1'b1));
        beat_last_s = (k_q == last_idx_s);
        if (idx_bad_s || (sa_idx == {IDX_W{1'b0}})) begin
            rd_addr_s = last_idx_s;
        end else begin
            rd_addr_s = sa_idx - IDX_W'(1'b1);
        end
    end

    // Drain FSM with its registered outputs and 1-deep output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            rd_bank_q     <= 1'b0;
            k_q           <= {IDX_W{1'b0}};
            prim_q        <= {IDX_W{1'b0}};
            sort_start_q  <= 1'b0;
            sort_len_q    <= {LEN_W{1'b0}};
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            out_data_q    <= {SYM_W{1'b0}};
            out_primary_q <= {IDX_W{1'b0}};
            err_q         <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (full_s[rd_bank_q]) begin
                        state_q      <= ST_REQ;
                        sort_start_q <= 1'b1;
                        sort_len_q   <= rd_len_s;
                    end
                end
                ST_REQ: begin
                    sort_start_q <= 1'b0;
                    k_q          <= {IDX_W{1'b0}};
                    prim_q       <= {IDX_W{1'b0}};
                    state_q      <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (sa_hs_s) begin
                        k_q <= k_q + IDX_W'(1'b1);
                        if (sa_idx == {IDX_W{1'b0}}) begin
                            prim_q <= k_q;
                        end
                        if (beat_last_s) begin
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (release_s) begin
                        rd_bank_q <= ~rd_bank_q;
                        state_q   <= ST_IDLE;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    sort_start_q <= 1'b0;
                end
            endcase

            if (sa_hs_s) begin
                out_valid_q <= 1'b1;
                out_data_q  <= rd_data_s;
                out_last_q  <= beat_last_s;
                if (beat_last_s) begin
                    out_primary_q <= (sa_idx == {IDX_W{1'b0}}) ? k_q : prim_q;
                end else begin
                    out_primary_q <= {IDX_W{1'b0}};
                end
                if (idx_bad_s) begin
                    err_q <= 1'b1;
                end
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
        end
    end

    assign in_ready    = in_ready_q;
    assign sort_start  = sort_start_q;
    assign sort_len    = sort_len_q;
    assign sa_ready    = sa_ready_s;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_last    = out_last_q;
    assign out_primary = out_primary_q;
    assign err         = err_q;

endmodule

// File: tb/tb_bwt_stream_core.sv
// Directed bench for bwt_stream_core with a small sorter driver and an
// expected-output scoreboard built from hand-derived BWT rules.
module tb_bwt_stream_core;

    localparam int SYM_W   = 8;
    localparam int MAX_LEN = 128;
    localparam int IDX_W   = 7;
    localparam int LEN_W   = 8;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic [SYM_W-1:0]         in_data = 8'h00;
    logic                     in_last = 1'b0;
    logic                     sort_start;
    logic [LEN_W-1:0]         sort_len;
    logic [MAX_LEN*SYM_W-1:0] sort_str;
    logic                     sa_valid = 1'b0;
    logic                     sa_ready;
    logic [IDX_W-1:0]         sa_idx = 7'd0;
    logic                     out_valid;
    logic                     out_ready;
    logic [SYM_W-1:0]         out_data;
    logic                     out_last;
    logic [IDX_W-1:0]         out_primary;
    logic                     err;

    int n_tests = 0;
    int n_fail  = 0;
    int start_cnt = 0;
    int consumed  = 0;
    int seen_len  = 0;
    bit rand_rdy  = 1'b0;
    bit prev_stall = 1'b0;
    logic [9:0] prev_word = 10'd0;

    logic [7:0] exp_d[$];
    bit         exp_l[$];
    int         exp_p[$];

    bwt_stream_core #(
        .SYM_W(SYM_W), .MAX_LEN(MAX_LEN), .IDX_W(IDX_W), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .sort_start(sort_start), .sort_len(sort_len), .sort_str(sort_str),
        .sa_valid(sa_valid), .sa_ready(sa_ready), .sa_idx(sa_idx),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_primary(out_primary), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Downstream ready: constant 1 or a coin flip per cycle.
    always @(posedge clk) begin
        #1;
        out_ready = rand_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    // Count sorter requests and remember the requested length.
    always @(negedge clk) begin
        if (rst_n && sort_start) begin
            start_cnt++;
            seen_len = int'(sort_len);
        end
    end

    // Output scoreboard plus hold-while-stalled check.
    always @(negedge clk) begin : mon
        logic [7:0] ed;
        bit         el;
        int         ep;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) chk("hold_stalled", {out_valid, out_last, out_data}, prev_word);
            if (out_valid && out_ready) begin
                if (exp_d.size() == 0) begin
                    chk("extra_beat", out_valid, 0);
                end else begin
                    ed = exp_d.pop_front();
                    el = exp_l.pop_front();
                    ep = exp_p.pop_front();
                    chk("out_data", out_data, ed);
                    chk("out_last", out_last, el);
                    if (el) chk("out_primary", out_primary, ep);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_word  = {out_valid, out_last, out_data};
        end
    end

    task automatic load_block(input logic [7:0] syms[$], input bit use_last, output int waits);
        int n;
        waits = 0;
        foreach (syms[i]) begin
            in_valid = 1'b1;
            in_data  = syms[i];
            in_last  = use_last && (i == syms.size() - 1);
            n = 0;
            while (!in_ready && n < 3000) begin
                @(posedge clk); #1;
                n++;
            end
            waits += n;
            chk("load_rdy", in_ready, 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Queue expected beats for the first n_feed SA entries, then act as the sorter.
    task automatic run_sort(input logic [7:0] syms[$], input int sa[$], input int n_feed);
        int n, len, prim;
        bit hs;
        len  = syms.size();
        prim = 0;
        for (int k = 0; k < n_feed; k++) begin
            if (sa[k] == 0) prim = k;
            exp_d.push_back((sa[k] == 0 || sa[k] >= len) ? syms[len-1] : syms[sa[k]-1]);
            exp_l.push_back(k == len - 1);
            exp_p.push_back(prim);
        end
        n = 0;
        while (start_cnt <= consumed && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("sort_start", (start_cnt > consumed), 1);
        consumed++;
        chk("sort_len", seen_len, len);
        chk("sort_str_first", sort_str[7:0], syms[0]);
        chk("sort_str_last", sort_str[(len-1)*8 +: 8], syms[len-1]);
        @(posedge clk); #1;
        for (int k = 0; k < n_feed; k++) begin
            sa_valid = 1'b1;
            sa_idx   = IDX_W'(sa[k]);
            hs = 1'b0;
            n  = 0;
            while (!hs && n < 3000) begin
                @(negedge clk);
                hs = sa_ready;
                @(posedge clk); #1;
                n++;
            end
            chk("sa_handshake", hs, 1);
        end
        sa_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_d.size() > 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drained", exp_d.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] banana[$], big[$], small4[$], one[$], blk_a[$], blk_b[$], blk_c[$];
        int sa_ban[$], sa_bad[$], ident[$];
        int w, w2, w3;
        banana = '{8'h62, 8'h61, 8'h6E, 8'h61, 8'h6E, 8'h61};
        sa_ban = '{5, 3, 1, 0, 4, 2};
        sa_bad = '{5, 3, 1, 0, 4, 7};
        small4 = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        blk_a  = '{8'h11, 8'h12};
        blk_b  = '{8'h21, 8'h22};
        blk_c  = '{8'h31, 8'h32};
        for (int i = 0; i < MAX_LEN; i++) begin
            big.push_back(8'(i));
            ident.push_back(i);
        end

        // Reset state
        #1;
        chk("reset_outputs", {in_ready, sort_start, sa_ready, out_valid, out_last,
                              out_data, out_primary, err}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rdy_before_edge", in_ready, 0);
        @(posedge clk); #1;
        chk("rdy_after_edge", in_ready, 1);

        // banana, full throughput
        load_block(banana, 1'b1, w);
        run_sort(banana, sa_ban, 6);
        wait_drain();
        chk("banana_err", err, 0);
        chk("sa_rdy_idle", sa_ready, 0);

        // banana with random backpressure
        rand_rdy = 1'b1;
        load_block(banana, 1'b1, w);
        run_sort(banana, sa_ban, 6);
        wait_drain();
        rand_rdy = 1'b0;

        // MAX_LEN block without in_last, second block loads during drain
        load_block(big, 1'b0, w);
        fork
            run_sort(big, ident, MAX_LEN);
            load_block(small4, 1'b1, w2);
        join
        chk("blk2_no_wait", w2, 0);
        run_sort(small4, '{2, 0, 3, 1}, 4);
        wait_drain();

        // single-symbol block
        one = '{8'h41};
        load_block(one, 1'b1, w);
        run_sort(one, '{0}, 1);
        wait_drain();

        // three blocks with the sorter stalled
        load_block(blk_a, 1'b1, w);
        load_block(blk_b, 1'b1, w);
        chk("both_full_rdy", in_ready, 0);
        fork
            load_block(blk_c, 1'b1, w3);
            begin
                repeat (5) @(posedge clk);
                #1;
                chk("full_rdy_hold", in_ready, 0);
                run_sort(blk_a, '{1, 0}, 2);
            end
        join
        chk("blk_c_waited", (w3 > 0), 1);
        run_sort(blk_b, '{1, 0}, 2);
        run_sort(blk_c, '{0, 1}, 2);
        wait_drain();

        // out-of-range SA index, then stickiness
        load_block(banana, 1'b1, w);
        run_sort(banana, sa_bad, 6);
        wait_drain();
        chk("err_set", err, 1);
        one = '{8'h42};
        load_block(one, 1'b1, w);
        run_sort(one, '{0}, 1);
        wait_drain();
        chk("err_sticky", err, 1);

        // reset in the middle of a stream
        load_block(banana, 1'b1, w);
        run_sort(banana, sa_ban, 3);
        repeat (2) @(posedge clk);
        #1;
        chk("pre_rst_drained", exp_d.size(), 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_outputs", {in_ready, sort_start, sa_ready, out_valid, out_last,
                               out_data, out_primary, err}, 0);
        consumed = start_cnt;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        load_block(banana, 1'b1, w);
        run_sort(banana, sa_ban, 6);
        wait_drain();
        chk("post_rst_err", err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bwt_stream_core.md
Name: bwt_stream_core

Overview:
Parametrised successor to the single-shot BWT top level. It accepts a symbol stream with valid/ready handshaking and variable block length (terminated by `in_last` or by reaching MAX_LEN). Blocks are buffered in ping-pong banks, so block N+1 loads while block N is transformed. An external suffix-array sorter is requested per block; the returned SA index stream is converted into the BWT output stream with backpressure and the primary index.

Parameters:
- SYM_W, 8, symbol width in bits
- MAX_LEN, 128, maximum block length in symbols (>=2)
- IDX_W, $clog2(MAX_LEN), width of symbol index
- LEN_W, $clog2(MAX_LEN+1), width of block length

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input symbol valid
- in_ready  out  1  core can accept a symbol
- in_data  in  SYM_W  input symbol
- in_last  in  1  final symbol of the block
- sort_start  out  1  one-cycle sorter request pulse
- sort_len  out  LEN_W  block length, held from sort_start until sort stream ends
- sort_str  out  MAX_LEN*SYM_W  drain-bank contents, symbol i at bits [i*SYM_W +: SYM_W], held as sort_len
- sa_valid  in  1  suffix-array index valid
- sa_ready  out  1  core accepts SA index
- sa_idx  in  IDX_W  next suffix-array entry (ascending suffix order)
- out_valid  out  1  BWT symbol valid
- out_ready  in  1  downstream accepts
- out_data  out  SYM_W  BWT symbol
- out_last  out  1  final BWT symbol of block
- out_primary  out  IDX_W  rank of original string; valid only on out_last beat
- err  out  1  sticky: sa_idx >= current block length

Behaviour:
- Reset (async, rst_n=0): all of the following are 0: banks' full flags, counters, in_ready, sort_start, sa_ready, out_valid, out_last, out_primary, out_data, err. Reset mid-block discards all buffered data. in_ready rises on the first clk edge after release.
- Load side:
  - wr_bank pointer, wr_cnt.
  - in_ready=1 iff bank[wr_bank] is not full.
  - A symbol is accepted on in_valid&&in_ready: it is written to bank[wr_bank][wr_cnt] and wr_cnt increments.
  - On an accepted beat with in_last=1, or with wr_cnt==MAX_LEN-1: latch len=wr_cnt+1 for that bank, set its full flag, toggle wr_bank, clear wr_cnt.
  - A length-1 block is legal.
- Drain FSM:
  - IDLE: when bank[rd_bank] is full, go to REQ.
  - REQ: assert sort_start for exactly 1 cycle with sort_len/sort_str valid; go to STREAM and clear k.
  - STREAM:
    - sa_ready = !out_valid || out_ready (1-deep output register, no bubble under full throughput).
    - On an sa handshake: out_data <= bank[rd_bank][sa_idx==0 ? len-1 : sa_idx-1]; out_valid <= 1; out_last <= (k==len-1); k++.
    - If sa_idx==0, latch prim<=k.
    - out_primary on the last beat = (sa_idx==0 at k==len-1) ? k : prim, using a same-cycle bypass.
    - After the last SA handshake go to DONE.
  - DONE:
    - Wait until the last beat is accepted (out_valid&&out_ready&&out_last).
    - Clear the full flag of rd_bank, toggle rd_bank, go to IDLE.
    - Minimum 1 idle cycle between blocks.
- Latency: sa handshake to out_valid is 1 cycle. Throughput is 1 symbol/cycle on both ports.
- Simultaneous events:
  - Load side filling bank A while drain releases bank B in the same cycle is legal.
  - The full-flag set and clear are for different banks and must not interfere.
  - If both banks are full, in_ready=0 until DONE releases one.
- out_valid must hold, with data stable, while out_ready=0.
- sa_valid with sa_idx>=len: set err, still emit a symbol using index 0; the stream count is unaffected.
- Extra sa_valid outside STREAM is ignored: sa_ready=0.
- A sort stream with more than len entries is not possible; the sorter is trusted for count.

Decomposition:
- Package bwt_pkg: drain-FSM enum (IDLE, REQ, STREAM, DONE), and default SYM_W/MAX_LEN constants.
- Sub-module bwt_bank_buf: two banks of MAX_LEN×SYM_W.
  - One write port and one random read port.
  - Flat read-out of the selected bank.
  - Per-bank len and full flags.
- bwt_stream_core holds the load counters and the drain FSM.

Test Plan:
- "banana" (0x62 0x61 0x6E 0x61 0x6E 0x61, in_last on 6th), model SA=[5,3,1,0,4,2] -> sort_len=6, out "n n b a a a" (6E 6E 62 61 61 61), out_last on 6th, out_primary=3, err=0.
- 128 symbols with no in_last -> block closes at MAX_LEN, sort_len=128. A second block is accepted during draining (in_ready stays 1 through the first).
- Random out_ready (50%) on "banana" -> identical output sequence, no drops or duplicates, data stable while stalled.
- Single symbol 0x41 with in_last, SA=[0] -> out 0x41, out_last=1, out_primary=0.
- Three back-to-back blocks with the sorter stalled -> in_ready drops after 2 full banks and recovers after the first block's last beat.
- sa_idx=7 for len 6 -> err=1, sticky until rst_n. Asserting rst_n mid-STREAM -> all outputs 0 immediately, and the next block processes correctly.
